// File: rtl/pre_read_arb_pkg.sv
// ============================================================================
// Module      : pre_read_arb_pkg
// Description : Shared state encodings and parameter limits for pre_read_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pre_read_arb_pkg;

    localparam int c_REQS_MAX    = 4;
    localparam int c_BURST_MAX   = 255;
    localparam int c_LATENCY_MAX = 3;
    localparam int c_BCNT_W      = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_GRANT = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pre_read_arb_rr_pick.sv
// ============================================================================
// Module      : pre_read_arb_rr_pick
// Description : Combinational round-robin select from a one-hot start pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_read_arb_rr_pick #(
    parameter int REQS = 2
) (
    input  logic [REQS-1:0] req,
    input  logic [REQS-1:0] ptr,
    output logic [REQS-1:0] gnt,
    output logic            any
);

    logic [REQS-1:0] w_hi;
    logic [REQS-1:0] w_hi_pick;
    logic [REQS-1:0] w_lo_pick;

    // Requests at or above the pointer win; otherwise wrap to the lowest one.
    assign w_hi      = req & ~(ptr - {{(REQS-1){1'b0}}, 1'b1});
    assign w_hi_pick = w_hi & (~w_hi + {{(REQS-1){1'b0}}, 1'b1});
    assign w_lo_pick = req & (~req + {{(REQS-1){1'b0}}, 1'b1});

    assign gnt = (|w_hi) ? w_hi_pick : w_lo_pick;
    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/pre_read_arb.sv
// ============================================================================
// Module      : pre_read_arb
// Description : Round-robin arbiter for the read side of a pre_read/BRAM pair,
//               with a latency-aligned per-requester valid/address tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_read_arb
    import pre_read_arb_pkg::*;
#(
    parameter int REQS    = 2,
    parameter int ADDRESS = 9,
    parameter int BURST   = 8,
    parameter int LATENCY = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [REQS-1:0]    req_i,
    input  logic               en_i,
    input  logic [ADDRESS-1:0] adr_i,
    output logic               rd_o,
    output logic [REQS-1:0]    gnt_o,
    output logic [REQS-1:0]    vld_o,
    output logic [ADDRESS-1:0] adr_o
);

    localparam int c_BURST = (BURST < 1) ? 1 : ((BURST > c_BURST_MAX) ? c_BURST_MAX : BURST);
    localparam int c_LAT   = (LATENCY < 1) ? 1 : ((LATENCY > c_LATENCY_MAX) ? c_LATENCY_MAX : LATENCY);
    localparam logic [c_BCNT_W-1:0] c_BURST_V    = c_BCNT_W'(c_BURST);
    localparam logic [c_BCNT_W-1:0] c_BURST_LAST = c_BCNT_W'(c_BURST - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [REQS-1:0]       r_gnt;
    logic [REQS-1:0]       r_ptr;
    logic [c_BCNT_W-1:0]   r_bcnt;
    logic [REQS-1:0]       w_pick;
    logic                  w_any;
    logic                  w_req_g;
    logic                  w_rd;
    logic                  w_pipe_busy;

    pre_read_arb_rr_pick #(
        .REQS (REQS)
    ) u_rr_pick (
        .req (req_i),
        .ptr (r_ptr),
        .gnt (w_pick),
        .any (w_any)
    );

    assign w_req_g = |(req_i & r_gnt);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                w_rd = w_req_g && en_i && (r_bcnt != c_BURST_V);
                if (!w_req_g || (w_rd && (r_bcnt == c_BURST_LAST))) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Pointer is one-hot; bit 0 set means search starts at requester 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_gnt  <= '0;
            r_ptr  <= {{(REQS-1){1'b0}}, 1'b1};
            r_bcnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_pick;
                    end
                end
                c_ST_GRANT: begin
                    if (w_rd) begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_gnt  <= '0;
                        r_ptr  <= {r_gnt[REQS-2:0], r_gnt[REQS-1]};
                        r_bcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < c_LAT; i++) begin : g_stage
        logic               r_v;
        logic [REQS-1:0]    r_g;
        logic [ADDRESS-1:0] r_a;
        logic               w_v_in;
        logic [REQS-1:0]    w_g_in;
        logic [ADDRESS-1:0] w_a_in;
        logic               w_busy;

        if (i == 0) begin : g_head
            assign w_v_in = w_rd;
            assign w_g_in = r_gnt;
            assign w_a_in = adr_i;
            assign w_busy = r_v;
        end else begin : g_tail
            assign w_v_in = g_stage[i-1].r_v;
            assign w_g_in = g_stage[i-1].r_g;
            assign w_a_in = g_stage[i-1].r_a;
            assign w_busy = r_v | g_stage[i-1].w_busy;
        end

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                r_v <= 1'b0;
                r_g <= '0;
                r_a <= '0;
            end else begin
                r_v <= w_v_in;
                r_g <= w_g_in;
                r_a <= w_a_in;
            end
        end
    end

    assign w_pipe_busy = g_stage[c_LAT-1].w_busy;

    assign rd_o  = w_rd;
    assign gnt_o = r_gnt;
    assign vld_o = g_stage[c_LAT-1].r_v ? g_stage[c_LAT-1].r_g : '0;
    assign adr_o = g_stage[c_LAT-1].r_a;

endmodule

`default_nettype wire

// File: tb/tb_pre_read_arb.sv
// ============================================================================
// Module      : tb_pre_read_arb
// Description : Self-checking bench for pre_read_arb (REQS=2, BURST=8, LATENCY=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pre_read_arb;

    localparam int REQS    = 2;
    localparam int ADDRESS = 9;
    localparam int BURST   = 8;
    localparam int LATENCY = 2;

    logic               clk_i;
    logic               reset_ni;
    logic [REQS-1:0]    req_i;
    logic               en_i;
    logic [ADDRESS-1:0] adr_i;
    logic               rd_o;
    logic [REQS-1:0]    gnt_o;
    logic [REQS-1:0]    vld_o;
    logic [ADDRESS-1:0] adr_o;

    pre_read_arb #(
        .REQS    (REQS),
        .ADDRESS (ADDRESS),
        .BURST   (BURST),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .req_i    (req_i),
        .en_i     (en_i),
        .adr_i    (adr_i),
        .rd_o     (rd_o),
        .gnt_o    (gnt_o),
        .vld_o    (vld_o),
        .adr_o    (adr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] req;
        logic       en;
        logic       rd;
        logic [1:0] gnt;
        logic [1:0] vld;
        logic [8:0] adr;
    } vec_t;

    typedef struct {
        int         due;
        logic [1:0] g;
        logic [8:0] a;
    } tag_t;

    vec_t tbl [13];
    tag_t sb [$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   rd_cnt   = 0;
    int   v1_cnt   = 0;
    logic pend_inc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected vld_o/adr_o come from a queue of tags pushed on every rd_o.
    task automatic sample();
        logic [1:0] ev;
        logic [8:0] ea;
        ev = 2'b00;
        ea = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            ev = sb[0].g;
            ea = sb[0].a;
            sb.delete(0);
        end
        chk("sb_vld", vld_o, ev);
        if (ev != 2'b00) chk("sb_adr", adr_o, ea);
        if (rd_o) begin
            chk("rd_needs_en", en_i, 1);
            chk("rd_needs_owner_req", |(req_i & gnt_o), 1);
            sb.push_back('{due: cyc + LATENCY, g: gnt_o, a: adr_i});
            rd_cnt++;
        end
        if (vld_o[1]) v1_cnt++;
        pend_inc = rd_o;
    endtask

    task automatic step(input logic [1:0] req, input logic en);
        @(posedge clk_i);
        #1;
        if (pend_inc) adr_i = adr_i + 1'b1;
        pend_inc = 1'b0;
        req_i = req;
        en_i  = en;
        cyc++;
        #1;
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] glog [3];
        int         rds [3];
        int         ngr;
        logic [1:0] prev;
        logic       done;
        logic [1:0] first_g;
        int         g1_rd;

        tbl[0]  = '{2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 9'd0};
        tbl[1]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 9'd0};
        tbl[2]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 9'd0};
        tbl[3]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 9'd0};
        tbl[4]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 9'd1};
        tbl[5]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 9'd2};
        tbl[6]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 9'd3};
        tbl[7]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 9'd4};
        tbl[8]  = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 9'd5};
        tbl[9]  = '{2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 9'd6};
        tbl[10] = '{2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 9'd7};
        tbl[11] = '{2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 9'd0};
        tbl[12] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 9'd0};

        reset_ni = 1'b0;
        req_i    = 2'b00;
        en_i     = 1'b1;
        adr_i    = '0;
        #2;
        chk("reset_rd", rd_o, 0);
        chk("reset_gnt", gnt_o, 0);
        chk("reset_vld", vld_o, 0);
        chk("reset_adr", adr_o, 0);
        repeat (3) @(posedge clk_i);
        #1 reset_ni = 1'b1;

        // Idle: no request, word available
        for (int k = 0; k < 20; k++) begin
            step(2'b00, 1'b1);
            chk("idle_rd", rd_o, 0);
            chk("idle_gnt", gnt_o, 0);
            chk("idle_vld", vld_o, 0);
        end

        // Single burst from the table
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req, tbl[i].en);
            chk($sformatf("single_rd[%0d]", i), rd_o, tbl[i].rd);
            chk($sformatf("single_gnt[%0d]", i), gnt_o, tbl[i].gnt);
            chk($sformatf("single_vld[%0d]", i), vld_o, tbl[i].vld);
            if (tbl[i].vld != 2'b00) chk($sformatf("single_adr[%0d]", i), adr_o, tbl[i].adr);
        end

        // Fairness: both requesting, pointer now at requester 1
        ngr  = 0;
        prev = 2'b00;
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            glog[i] = 2'b00;
            rds[i]  = 0;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            step((ngr >= 3 && rds[2] >= BURST) ? 2'b00 : 2'b11, 1'b1);
            if (gnt_o != 2'b00 && prev == 2'b00) begin
                if (ngr < 3) glog[ngr] = gnt_o;
                ngr++;
            end
            if (rd_o && ngr >= 1 && ngr <= 3) rds[ngr-1]++;
            if (ngr >= 3 && gnt_o == 2'b00 && prev != 2'b00) done = 1'b1;
            prev = gnt_o;
        end
        chk("fair_done", done, 1);
        chk("fair_ngrants", ngr, 3);
        chk("fair_g0", glog[0], 2'b10);
        chk("fair_g1", glog[1], 2'b01);
        chk("fair_g2", glog[2], 2'b10);
        chk("fair_rd0", rds[0], BURST);
        chk("fair_rd1", rds[1], BURST);
        chk("fair_rd2", rds[2], BURST);

        // Stall: en_i low for 5 cycles after 3 reads
        rd_cnt = 0;
        for (int k = 0; k < 40 && rd_cnt < 3; k++) step(2'b01, 1'b1);
        chk("stall_pre_reads", rd_cnt, 3);
        for (int k = 0; k < 5; k++) begin
            step(2'b01, 1'b0);
            chk("stall_rd", rd_o, 0);
            chk("stall_gnt", gnt_o, 2'b01);
        end
        for (int k = 0; k < 40; k++) begin
            step((rd_cnt >= BURST) ? 2'b00 : 2'b01, 1'b1);
            if (gnt_o == 2'b00) break;
        end
        chk("stall_end_gnt", gnt_o, 0);
        chk("stall_reads", rd_cnt, BURST);

        // Early drop: requester 1 releases after 3 reads
        rd_cnt = 0;
        v1_cnt = 0;
        for (int k = 0; k < 40 && rd_cnt < 3; k++) step(2'b10, 1'b1);
        chk("drop_pre_reads", rd_cnt, 3);
        step(2'b00, 1'b1);
        chk("drop_no_rd", rd_o, 0);
        chk("drop_gnt_held", gnt_o, 2'b10);
        for (int k = 0; k < 20; k++) begin
            step(2'b00, 1'b1);
            if (gnt_o == 2'b00) break;
        end
        chk("drop_end_gnt", gnt_o, 0);
        chk("drop_reads", rd_cnt, 3);
        chk("drop_vld1", v1_cnt, 3);

        // Pointer back at 0, then interrupt requester 1 with two reads in flight
        first_g = 2'b00;
        g1_rd   = 0;
        for (int k = 0; k < 60; k++) begin
            step(2'b11, 1'b1);
            if (first_g == 2'b00 && gnt_o != 2'b00) first_g = gnt_o;
            if (gnt_o == 2'b10 && rd_o) g1_rd++;
            if (g1_rd == 2) break;
        end
        chk("drop_next_grant", first_g, 2'b01);
        chk("rst_pre_reads", g1_rd, 2);

        reset_ni = 1'b0;
        #1;
        chk("midrst_rd", rd_o, 0);
        chk("midrst_gnt", gnt_o, 0);
        chk("midrst_vld", vld_o, 0);
        chk("midrst_adr", adr_o, 0);
        sb.delete();
        @(posedge clk_i);
        #1;
        if (pend_inc) adr_i = adr_i + 1'b1;
        pend_inc = 1'b0;
        reset_ni = 1'b1;
        cyc++;
        #1;
        chk("postrst_vld", vld_o, 0);
        chk("postrst_gnt", gnt_o, 0);

        first_g = 2'b00;
        for (int k = 0; k < 10 && first_g == 2'b00; k++) begin
            step(2'b11, 1'b1);
            first_g = gnt_o;
        end
        chk("postrst_grant", first_g, 2'b01);
        for (int k = 0; k < 4; k++) step(2'b11, 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(2'b00, 1'b1);
            if (gnt_o == 2'b00) break;
        end
        repeat (3) step(2'b00, 1'b1);
        chk("final_gnt", gnt_o, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
